// File: rtl/moore_seq_detector.sv
// moore_seq_detector: Moore FSM flagging serial pattern 1101, overlapping detection
module moore_seq_detector (
  input  logic       clk,
  input  logic       rst,
  input  logic       x,
  output logic       y,
  output logic [2:0] state
);
  typedef enum logic [2:0] {S0 = 3'b000, S1 = 3'b001, S2 = 3'b010, S3 = 3'b011, S4 = 3'b100} state_e;
  logic [2:0] st, nxt;
  always_comb
    case (st)
      S0:      nxt = x ? S1 : S0;
      S1:      nxt = x ? S2 : S0;
      S2:      nxt = x ? S2 : S3;
      S3:      nxt = x ? S4 : S0;
      S4:      nxt = x ? S2 : S0;
      default: nxt = S0;
    endcase
  always_ff @(posedge clk or negedge rst)
    if (!rst) st <= S0;
    else st <= nxt;
  assign y = st == S4;
  assign state = st;
endmodule

// File: tb/tb_moore_seq_detector.sv
// tb_moore_seq_detector: scoreboard bench for the 1101 Moore detector
module tb_moore_seq_detector;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic x = 1'b0;
  logic y;
  logic [2:0] state;
  int checks = 0;
  int errors = 0;
  logic [3:0] q[$];

  moore_seq_detector dut (.clk(clk), .rst(rst), .x(x), .y(y), .state(state));

  always #5 clk = ~clk;

  task automatic drive(input logic b, input logic [2:0] s);
    x = b;
    q.push_back({s, s == 3'd4});
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string name, input logic [15:0] bits, input int n, input logic [47:0] exp);
    logic [3:0] e;
    for (int i = 0; i < n; i++) begin
      drive(bits[i], exp[3*i +: 3]);
      e = q.pop_front();
      checks++;
      if ({state, y} !== e) begin
        errors++;
        $display("FAIL %s step %0d: got state=%0d y=%b, expected state=%0d y=%b",
                 name, i, state, y, e[3:1], e[0]);
      end
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({state, y} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_async: got state=%0d y=%b, expected state=0 y=0", state, y);
    end
    x = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({state, y} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_held: got state=%0d y=%b, expected state=0 y=0", state, y);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_detect();
    rst = 1'b0;
    #1;
    rst = 1'b1;
    run("detect", 16'b1011, 4, {3'd4, 3'd3, 3'd2, 3'd1});
  endtask

  task automatic test_overlap();
    run("overlap", 16'b0101, 4, {3'd0, 3'd4, 3'd3, 3'd2});
  endtask

  task automatic test_run_of_ones();
    run("ones", 16'b0101111, 7, {3'd0, 3'd4, 3'd3, 3'd2, 3'd2, 3'd2, 3'd1});
  endtask

  task automatic test_no_match();
    run("nomatch", 16'b0010100101, 10,
        {3'd0, 3'd0, 3'd1, 3'd0, 3'd1, 3'd0, 3'd0, 3'd1, 3'd0, 3'd1});
  endtask

  task automatic test_back_to_back();
    run("b2b", 16'b01011011, 8, {3'd0, 3'd4, 3'd3, 3'd2, 3'd4, 3'd3, 3'd2, 3'd1});
  endtask

  task automatic test_async_reset();
    run("pre_rst", 16'b011, 3, {3'd3, 3'd2, 3'd1});
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({state, y} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_in_s3: got state=%0d y=%b, expected state=0 y=0", state, y);
    end
    @(negedge clk);
    rst = 1'b1;
    run("post_rst", 16'b1011, 4, {3'd4, 3'd3, 3'd2, 3'd1});
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({state, y} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_in_s4: got state=%0d y=%b, expected state=0 y=0", state, y);
    end
    @(negedge clk);
    rst = 1'b1;
    run("restart", 16'b1, 1, {3'd1});
    run("clear", 16'b0, 1, {3'd0});
  endtask

  task automatic test_illegal();
    logic [2:0] code;
    for (int c = 5; c < 8; c++)
      for (int b = 0; b < 2; b++) begin
        code = 3'(c);
        @(negedge clk);
        force dut.st = code;
        #1;
        checks++;
        if ({state, y} !== {code, 1'b0}) begin
          errors++;
          $display("FAIL illegal_hold %0d: got state=%0d y=%b, expected state=%0d y=0", c, state, y, code);
        end
        release dut.st;
        run("illegal_exit", 16'(b), 1, {3'd0});
        if (b == 1) run("illegal_fix", 16'b0, 1, {3'd0});
      end
  endtask

  initial begin
    test_reset();
    test_detect();
    test_overlap();
    test_run_of_ones();
    test_no_match();
    test_back_to_back();
    test_async_reset();
    test_illegal();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
